// File: rtl/data_sampler_trigger_pkg.sv
// Shared definitions for the sampling FIFO front end.
// Holds the capture FSM state encoding and the default word/length widths
// used by the FIFO stages.
package data_sampler_trigger_pkg;

    localparam int DATA_WIDTH_DEF = 512;
    localparam int LEN_WIDTH_DEF  = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/data_sampler_trigger_edge_detect.sv
// Rising-edge detector for the external trigger.
// Ports:
//   clk   - sample clock
//   rst   - asynchronous active-high reset
//   trig  - trigger level, synchronous to clk
//   rise  - high for the cycle in which trig goes 0 -> 1
// The delayed copy is updated every cycle regardless of the capture state, so
// a trigger already high when the capture is armed never looks like an edge.
module data_sampler_trigger_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic trig,
    output logic rise
);

    logic trig_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_q <= 1'b0;
        end else begin
            trig_q <= trig;
        end
    end

    assign rise = trig & ~trig_q;

endmodule

// File: rtl/data_sampler_trigger.sv
// Gated snippet capture in front of the wide sampling FIFO.
// Once armed and triggered, forwards exactly LENGTH valid sample words to the
// FIFO write port, then stops and reports status.
// Ports:
//   CLK, RESET        - sample clock, asynchronous active-high reset
//   DIN, DIN_VALID    - continuous sample stream
//   START, ABORT      - single-cycle control pulses (ABORT wins)
//   TRIG_SEL, TRIG    - 0: immediate trigger, 1: rising edge of TRIG
//   LENGTH            - snippet length, latched on START
//   FIFO_FULL         - FIFO write-side full flag
//   DOUT, DOUT_VALID  - FIFO din / wr_en, registered
//   BUSY, DONE        - registered state decodes
//   OVERFLOW          - sticky: a forwarded word met FIFO_FULL
//   WORDS_CAPTURED    - words forwarded in the current or last snippet
//
// state   | meaning
// IDLE    | waiting for START
// ARMED   | LENGTH latched, waiting for the trigger
// CAPTURE | forwarding valid words until LENGTH reached
// DONE    | snippet complete, holding status until re-armed
module data_sampler_trigger
    import data_sampler_trigger_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [DATA_WIDTH-1:0] DIN,
    input  logic                  DIN_VALID,
    input  logic                  START,
    input  logic                  ABORT,
    input  logic                  TRIG_SEL,
    input  logic                  TRIG,
    input  logic [LEN_WIDTH-1:0]  LENGTH,
    input  logic                  FIFO_FULL,
    output logic [DATA_WIDTH-1:0] DOUT,
    output logic                  DOUT_VALID,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  OVERFLOW,
    output logic [LEN_WIDTH-1:0]  WORDS_CAPTURED
);

    state_t                  state;
    state_t                  state_next;
    logic                    trig_rise;
    logic                    arm;
    logic                    accept;
    logic [LEN_WIDTH-1:0]    len_q;
    logic [LEN_WIDTH-1:0]    words_q;
    logic [LEN_WIDTH-1:0]    words_inc;
    logic                    overflow_q;
    logic [DATA_WIDTH-1:0]   dout_q;
    logic                    dout_valid_q;
    logic                    busy_q;
    logic                    done_q;

    data_sampler_trigger_edge_detect u_edge (
        .clk  (CLK),
        .rst  (RESET),
        .trig (TRIG),
        .rise (trig_rise)
    );

    assign words_inc = words_q + LEN_WIDTH'(1);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ABORT overrides everything, including a START or trigger in the same
    // cycle; the word being accepted in that cycle is not forwarded.
    always_comb begin
        state_next = state;
        arm        = 1'b0;
        accept     = 1'b0;
        if (ABORT) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (START) begin
                        arm        = 1'b1;
                        state_next = (LENGTH == '0) ? ST_DONE : ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (!TRIG_SEL || trig_rise) begin
                        state_next = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (DIN_VALID) begin
                        accept = 1'b1;
                        if (words_inc == len_q) begin
                            state_next = ST_DONE;
                        end
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // A word meeting FIFO_FULL is still strobed and counted so the snippet
    // spans a fixed time window; the loss is flagged through OVERFLOW.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            len_q        <= '0;
            words_q      <= '0;
            overflow_q   <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            busy_q       <= (state_next == ST_ARMED) || (state_next == ST_CAPTURE);
            done_q       <= (state_next == ST_DONE);
            dout_valid_q <= accept;
            if (accept) begin
                dout_q  <= DIN;
                words_q <= words_inc;
                if (FIFO_FULL) begin
                    overflow_q <= 1'b1;
                end
            end
            if (arm) begin
                len_q      <= LENGTH;
                words_q    <= '0;
                overflow_q <= 1'b0;
            end
        end
    end

    assign DOUT           = dout_q;
    assign DOUT_VALID     = dout_valid_q;
    assign BUSY           = busy_q;
    assign DONE           = done_q;
    assign OVERFLOW       = overflow_q;
    assign WORDS_CAPTURED = words_q;

endmodule
